time_keeper: RTL

- Consumes the 1 Hz square wave from the divider and advances a 24-hour HH:MM:SS time-of-day count in packed BCD.
- Runs entirely in the 100 MHz domain: samples the 1 Hz level, detects its rising edge, and steps seconds once per edge.
- Also accepts a validated time-load request and minute/hour adjust pulses from the button/UI logic.
- Drives the display formatter and the alarm comparator.

---
 rtl/time_keeper.sv | 99 +++++++++
 1 files changed

// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS time-of-day counter in packed BCD, stepped by the rising edge of a 1 Hz level.
// Also accepts a checked time load and minute/hour adjust pulses, with load > adjust > tick priority.
module time_keeper #(
  parameter int HOUR_LIMIT = 24
) (
  input  logic       clk_100mhz,
  input  logic       rst_100mhz,
  input  logic       in_1hz,
  input  logic       run_en,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       day_carry,
  output logic       load_ack,
  output logic       load_err
);

  localparam logic [3:0] HMAX_T = 4'((HOUR_LIMIT - 1) / 10);
  localparam logic [3:0] HMAX_U = 4'((HOUR_LIMIT - 1) % 10);
  localparam logic [7:0] HMAX   = {HMAX_T, HMAX_U};
  localparam logic [7:0] MS_MAX = 8'h59;

  // Returns {wrapped, next}; wraps to 00 when the field is at its maximum.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 9'h100;
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic nib_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic       prev;
  logic       rise;
  logic       load_valid;
  logic [8:0] ss_n, mm_n, hh_n;

  assign rise     = in_1hz & ~prev;
  assign ss_n     = bcd_inc(ss, MS_MAX);
  assign mm_n     = bcd_inc(mm, MS_MAX);
  assign hh_n     = bcd_inc(hh, HMAX);
  // With every nibble legal, a plain binary compare orders BCD values correctly.
  assign load_valid = nib_ok(load_hh) && nib_ok(load_mm) && nib_ok(load_ss) &&
                      (load_ss <= MS_MAX) && (load_mm <= MS_MAX) && (load_hh <= HMAX);

  always_ff @(posedge clk_100mhz) begin
    if (rst_100mhz) begin
      prev      <= in_1hz;
      hh        <= 8'h00;
      mm        <= 8'h00;
      ss        <= 8'h00;
      sec_tick  <= 1'b0;
      day_carry <= 1'b0;
      load_ack  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      prev      <= in_1hz;
      sec_tick  <= 1'b0;
      day_carry <= 1'b0;
      load_ack  <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        if (load_valid) begin
          hh       <= load_hh;
          mm       <= load_mm;
          ss       <= load_ss;
          load_ack <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end else if (inc_min || inc_hour) begin
        if (inc_min) begin
          mm <= mm_n[7:0];
          ss <= 8'h00;
        end
        if (inc_hour) hh <= hh_n[7:0];
      end else if (rise && run_en) begin
        sec_tick <= 1'b1;
        ss       <= ss_n[7:0];
        if (ss_n[8]) begin
          mm <= mm_n[7:0];
          if (mm_n[8]) begin
            hh        <= hh_n[7:0];
            day_carry <= hh_n[8];
          end
        end
      end
    end
  end

endmodule
